// File: rtl/ram_fifo_ctrl_pkg.sv
// ============================================================================
//  Module   : ram_ctrl_pkg
//  Purpose  : Shared sizing helpers and pointer wrap function for ram_fifo_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

    // Address width that never collapses to zero bits for tiny depths.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Level must represent DEPTH + 2 (RAM plus in-flight read plus two skid slots).
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 3);
    endfunction

    // Explicit wrap so non power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_fifo_ctrl_if.sv
// ============================================================================
//  Module   : ram_fifo_ctrl_if
//  Purpose  : Producer, consumer and RAM port bundle of the RAM-backed FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 4096,
    parameter int DEPTH      = 64
);
    import ram_ctrl_pkg::*;

    localparam int ADDR_W = clog2_safe(DEPTH);
    localparam int LVL_W  = lvl_w(DEPTH);

    logic                  flush;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [ADDR_W-1:0]     ram_raddr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [LVL_W-1:0]      level;

    // Controller side.
    modport master (
        input  flush, s_valid, s_data, m_ready, ram_dout,
        output s_ready, m_valid, m_data, ram_we, ram_waddr, ram_raddr, ram_din, level
    );

    // Environment side: producer, consumer and RAM.
    modport slave (
        output flush, s_valid, s_data, m_ready, ram_dout,
        input  s_ready, m_valid, m_data, ram_we, ram_waddr, ram_raddr, ram_din, level
    );

endinterface

`default_nettype wire

// File: rtl/ram_fifo_ctrl_skid2_buf.sv
// ============================================================================
//  Module   : skid2_buf
//  Purpose  : Two-entry output FIFO absorbing the RAM's registered read data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid2_buf #(
    parameter int DATA_WIDTH = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic [1:0]            cnt;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else if (flush) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= din;
                    else             entry1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    // Head leaves while a new word arrives; count holds.
                    if (cnt == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end else begin
                        entry0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (cnt != 2'd0);
    assign head  = valid ? entry0 : '0;
    assign count = cnt;

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
//  Module   : ram_fifo_ctrl
//  Purpose  : Runs a 1W1R RAM as a circular FIFO, hiding read latency in a skid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 4096,
    parameter int DEPTH      = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_fifo_ctrl_if.master bus
);

    localparam int ADDR_W = clog2_safe(DEPTH);
    localparam int LVL_W  = lvl_w(DEPTH);

    logic [ADDR_W-1:0]     wptr;
    logic [ADDR_W-1:0]     rptr;
    logic [LVL_W-1:0]      mem_cnt;
    logic                  inflight;
    logic                  ready_en;
    logic                  s_ready_int;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  skid_push;
    logic                  skid_valid;
    logic [1:0]            skid_cnt;
    logic [DATA_WIDTH-1:0] skid_head;

    // Producer handshake; refused during flush so no accepted word is dropped.
    assign s_ready_int = ready_en && !bus.flush && (mem_cnt < LVL_W'(DEPTH));
    assign push        = bus.s_valid && s_ready_int;
    assign pop         = skid_valid && bus.m_ready;

    // Issue only if the skid can still take the word when it returns.
    assign issue = (mem_cnt != '0) && !bus.flush &&
                   (({1'b0, skid_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    // Returning data is dropped when a flush lands on the capture edge.
    assign skid_push = inflight && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (bus.flush) begin
                wptr     <= '0;
                rptr     <= '0;
                mem_cnt  <= '0;
                inflight <= 1'b0;
            end else begin
                if (push)  wptr <= ADDR_W'(ptr_inc(32'(wptr), DEPTH));
                if (issue) rptr <= ADDR_W'(ptr_inc(32'(rptr), DEPTH));
                inflight <= issue;
                case ({push, issue})
                    2'b10:   mem_cnt <= mem_cnt + LVL_W'(1);
                    2'b01:   mem_cnt <= mem_cnt - LVL_W'(1);
                    default: ;
                endcase
            end
        end
    end

    skid2_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (skid_push),
        .pop   (pop),
        .din   (bus.ram_dout),
        .valid (skid_valid),
        .head  (skid_head),
        .count (skid_cnt)
    );

    assign bus.s_ready   = s_ready_int;
    assign bus.ram_we    = push;
    assign bus.ram_waddr = wptr;
    assign bus.ram_raddr = rptr;
    assign bus.ram_din   = bus.s_data;
    assign bus.m_valid   = skid_valid;
    assign bus.m_data    = skid_head;
    assign bus.level     = mem_cnt + LVL_W'(inflight) + LVL_W'(skid_cnt);

endmodule

`default_nettype wire

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Sequencer that runs one ram_1w1r instance as a circular FIFO between a producer (MAC result writer) and a consumer (next-stage reader), with valid/ready on both sides.
- Owns write/read pointers and occupancy, and drives the RAM write and read ports.
- Hides the RAM's 1-cycle registered read latency behind a 2-entry output skid buffer, so the consumer sees a plain FIFO at full throughput.

Parameters:
- DATA_WIDTH, 4096, word width; must match the attached RAM.
- DEPTH, 64, RAM entries; any value >= 2, power of two not required.
- ADDR_W, clog2_safe(DEPTH), derived localparam for RAM address width.
- LVL_W, $clog2(DEPTH+3), derived localparam for level width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO state
- s_valid  in  1  producer word valid
- s_ready  out  1  controller can accept a word
- s_data  in  DATA_WIDTH  producer word
- m_valid  out  1  head word valid
- m_ready  in  1  consumer takes head word
- m_data  out  DATA_WIDTH  head word
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_W  RAM write address
- ram_raddr  out  ADDR_W  RAM read address
- ram_din  out  DATA_WIDTH  RAM write data (= s_data)
- ram_dout  in  DATA_WIDTH  RAM registered read data
- level  out  LVL_W  words held (RAM + in-flight + skid)

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. While low, all state clears immediately, no clock needed.
  - wptr, rptr and mem_cnt = 0; inflight = 0; skid empty.
  - Outputs go to: m_valid = 0, m_data = 0, level = 0, ram_we = 0, s_ready = 0.
  - s_ready goes to 1 on the first edge after release. RAM contents are don't-care.
- Push: s_ready = (mem_cnt < DEPTH). On s_valid && s_ready:
  - ram_we = 1 combinationally, ram_waddr = wptr, ram_din = s_data.
  - wptr advances, wrapping explicitly DEPTH-1 -> 0.
- Read issue: issue when mem_cnt > 0 && (skid_cnt + inflight - pop) < 2, where pop = m_valid && m_ready.
  - ram_raddr = rptr (driven continuously); rptr advances with wrap; inflight <= 1.
  - mem_cnt counts only words written on earlier edges, so a read never targets the address being written in the same cycle (the RAM returns old data on collision).
- Capture: on the edge after issue, ram_dout is valid. The skid stores it on the following edge and inflight clears unless a new read was issued.
- Skid: 2-entry FIFO.
  - m_valid = skid non-empty; m_data = skid head (0 when empty).
  - Capacity reasoning guarantees a capture never overflows it.
- Latency: push sampled at edge N with FIFO empty and m_ready = 1 -> m_valid high after edge N+2.
- Throughput: 1 word/cycle sustained with continuous s_valid and m_ready.
- Ordering: strict FIFO order; no loss or duplication under any m_ready pattern.
- mem_cnt update:
  - push only -> +1
  - issue only -> -1
  - both -> unchanged
- level = mem_cnt + inflight + skid_cnt. Maximum is DEPTH+2.
- Simultaneous push and pop at full:
  - s_ready is 0 that cycle, so the push is not taken.
  - The pop frees a skid slot, so a read issues and mem_cnt drops; s_ready is 1 on the next cycle.
- flush (synchronous, priority over push/pop):
  - Clears pointers, counts and skid, and sets inflight = 0.
  - Any ram_dout arriving on the next edge is discarded.
  - ram_we = 0 during a flush cycle.
- rst_n asserted mid-operation: immediate clear as in Reset; any in-flight read is discarded.

Decomposition:
- Package ram_ctrl_pkg: clog2_safe function; ptr_inc(ptr, DEPTH) wrap helper; LVL_W formula.
- One sub-module: skid2_buf. It is a 2-entry DATA_WIDTH FIFO with push/pop/flush and count output, using asynchronous active-low reset.
- Pointer and count logic stay in ram_fifo_ctrl.

Test Plan (DEPTH=4, DATA_WIDTH=16, RAM model attached):
- Single word: push 16'hA5A5 at edge N, m_ready=1 -> m_valid high after edge N+2 with m_data=16'hA5A5, one cycle; level returns 0.
- Fill with m_ready=0: offer 8 words 16'h0000..16'h0007 -> exactly 6 accepted; s_ready low after 6th; level=6; m_data=16'h0000 held.
- Stream 20 words (16'h0100+i) with s_valid and m_ready always high -> after 2-cycle latency one word per cycle in order; ram_waddr/ram_raddr wrap 3->0; s_ready never drops.
- Random m_ready (50%) and s_valid (70%), 500 words -> scoreboard shows exact order, no loss or duplication; level equals scoreboard depth every cycle.
- At level=6, s_valid=1 and m_ready=1 same cycle -> push refused, pop of 16'h0000 taken; s_ready=1 next cycle, accepted push lands at wrapped address.
- flush with inflight=1 and skid=2 -> next cycle level=0, m_valid=0, stale word never appears. Then assert rst_n low mid-stream between edges -> m_valid, level and ram_we are 0 with no clock edge.
